// File: rtl/ssd_scan_driver.sv
// Multiplexed seven-segment driver with a sequential double-dabble converter.
// Define SSD_LEADING_ZERO_BLANK_EN to blank leading zero digits.
module ssd_scan_driver #(
    parameter int DIGITS        = 4,
    parameter int VALUE_W       = 14,
    parameter int REFRESH_DIV_W = 18
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [VALUE_W-1:0] num,
    input  logic               load,
    output logic               busy,
    output logic               done,
    output logic               overflow,
    output logic [DIGITS-1:0]  Anode,
    output logic [6:0]         LED_out
);

    localparam int BW    = 4 * DIGITS;
    localparam int SW    = BW + VALUE_W;
    localparam int IDX_W = $clog2(DIGITS);
    localparam int IW    = $clog2(VALUE_W + 1);
    localparam logic [63:0] MAXV = 64'(10 ** DIGITS) - 64'd1;
    localparam logic [6:0] DASH  = 7'b1111110;
    localparam logic [6:0] BLANK = 7'b1111111;

    typedef enum logic {S_IDLE, S_CONV} state_t;

    state_t                   state_q;
    logic                     done_q;
    logic                     ovf_q;
    logic [SW-1:0]            sh_q;
    logic [SW-1:0]            sh_d;
    logic [SW-1:0]            sh_tmp;
    logic [VALUE_W-1:0]       val_q;
    logic [IW-1:0]            iter_q;
    logic [BW-1:0]            disp_q;
    logic [REFRESH_DIV_W-1:0] cnt_q;
    logic [IDX_W-1:0]         idx_q;
    logic [IDX_W-1:0]         sel;
    logic [DIGITS-1:0]        anode_q;
    logic [DIGITS-1:0]        anode_d;
    logic [6:0]               led_q;
    logic [6:0]               led_d;
    logic [3:0]               dig;
    logic                     blank;
`ifdef SSD_LEADING_ZERO_BLANK_EN
    logic                     seen;
`endif

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'b0000001;
            4'd1:    seg7 = 7'b1001111;
            4'd2:    seg7 = 7'b0010010;
            4'd3:    seg7 = 7'b0000110;
            4'd4:    seg7 = 7'b1001100;
            4'd5:    seg7 = 7'b0100100;
            4'd6:    seg7 = 7'b0100000;
            4'd7:    seg7 = 7'b0001111;
            4'd8:    seg7 = 7'b0000000;
            4'd9:    seg7 = 7'b0000100;
            default: seg7 = BLANK;
        endcase
    endfunction

    // One double-dabble step: add 3 to every BCD nibble >= 5, then shift left.
    always_comb begin
        sh_tmp = sh_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (sh_tmp[VALUE_W+4*i +: 4] > 4'd4)
                sh_tmp[VALUE_W+4*i +: 4] = sh_tmp[VALUE_W+4*i +: 4] + 4'd3;
        end
        sh_d = {sh_tmp[SW-2:0], 1'b0};
    end

    // Scan index 0 is the leftmost digit.
    always_comb begin
        sel     = IDX_W'(DIGITS - 1) - idx_q;
        anode_d = '1;
        dig     = '0;
        blank   = 1'b0;
`ifdef SSD_LEADING_ZERO_BLANK_EN
        seen    = 1'b0;
`endif
        for (int i = DIGITS - 1; i >= 0; i--) begin
`ifdef SSD_LEADING_ZERO_BLANK_EN
            seen = seen | (disp_q[4*i +: 4] != 4'd0);
`endif
            if (IDX_W'(i) == sel) begin
                anode_d[i] = 1'b0;
                dig        = disp_q[4*i +: 4];
`ifdef SSD_LEADING_ZERO_BLANK_EN
                blank      = !seen && (i != 0);
`endif
            end
        end
        if (ovf_q)
            led_d = DASH;
        else if (blank)
            led_d = BLANK;
        else
            led_d = seg7(dig);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
            sh_q    <= '0;
            val_q   <= '0;
            iter_q  <= '0;
            disp_q  <= '0;
            cnt_q   <= '0;
            idx_q   <= '0;
            anode_q <= '1;
            led_q   <= BLANK;
        end else begin
            cnt_q   <= cnt_q + 1'b1;
            if (&cnt_q)
                idx_q <= (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
            anode_q <= anode_d;
            led_q   <= led_d;
            done_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (load) begin
                        state_q <= S_CONV;
                        sh_q    <= {{BW{1'b0}}, num};
                        val_q   <= num;
                        iter_q  <= IW'(VALUE_W - 1);
                    end
                end
                S_CONV: begin
                    sh_q   <= sh_d;
                    iter_q <= iter_q - 1'b1;
                    if (iter_q == '0) begin
                        state_q <= S_IDLE;
                        done_q  <= 1'b1;
                        disp_q  <= sh_d[SW-1 -: BW];
                        ovf_q   <= (64'(val_q) > MAXV);
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy     = (state_q == S_CONV);
    assign done     = done_q;
    assign overflow = ovf_q;
    assign Anode    = anode_q;
    assign LED_out  = led_q;

endmodule

// File: tb/tb_ssd_scan_driver.sv
// Bench for ssd_scan_driver: a 4-digit and a 6-digit instance against a value-level model.
module tb_ssd_scan_driver;

`ifdef SSD_LEADING_ZERO_BLANK_EN
    localparam bit LZB = 1'b1;
`else
    localparam bit LZB = 1'b0;
`endif
    localparam logic [6:0] SEG [10] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
        7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100};
    localparam logic [6:0] DASH = 7'b1111110;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic        load_a = 1'b0, load_b = 1'b0;
    logic [13:0] num_a = '0;
    logic [19:0] num_b = '0;
    logic        busy_a, done_a, ovf_a, busy_b, done_b, ovf_b;
    logic [3:0]  an_a;
    logic [5:0]  an_b;
    logic [6:0]  led_a, led_b;

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    ssd_scan_driver #(.DIGITS(4), .VALUE_W(14), .REFRESH_DIV_W(2)) dut_a (
        .clk(clk), .rst(rst), .num(num_a), .load(load_a),
        .busy(busy_a), .done(done_a), .overflow(ovf_a),
        .Anode(an_a), .LED_out(led_a));

    ssd_scan_driver #(.DIGITS(6), .VALUE_W(20), .REFRESH_DIV_W(1)) dut_b (
        .clk(clk), .rst(rst), .num(num_b), .load(load_b),
        .busy(busy_b), .done(done_b), .overflow(ovf_b),
        .Anode(an_b), .LED_out(led_b));

    function automatic int pd(int i);  return (i == 0) ? 4 : 6;   endfunction
    function automatic int pvw(int i); return (i == 0) ? 14 : 20; endfunction
    function automatic int pr(int i);  return (i == 0) ? 2 : 1;   endfunction

    function automatic longint pw10(int p);
        longint r = 1;
        for (int k = 0; k < p; k++) r = r * 10;
        return r;
    endfunction

    function automatic logic [6:0] exp_seg(int i, longint v, int pos);
        if (v > pw10(pd(i)) - 1) return DASH;
        if (LZB && pos != 0 && v < pw10(pos)) return 7'h7F;
        return SEG[int'((v / pw10(pos)) % 10)];
    endfunction

    // Value-level model: pending value, cycles left, value on display.
    logic   ld [2];
    longint nm [2];
    logic [7:0] an_act [2];
    logic [6:0] led_act [2];
    logic   bsy_act [2], dn_act [2], ov_act [2];
    always_comb begin
        ld[0] = load_a; ld[1] = load_b;
        nm[0] = longint'(num_a); nm[1] = longint'(num_b);
        an_act[0] = {4'h0, an_a}; an_act[1] = {2'h0, an_b};
        led_act[0] = led_a; led_act[1] = led_b;
        bsy_act[0] = busy_a; bsy_act[1] = busy_b;
        dn_act[0] = done_a; dn_act[1] = done_b;
        ov_act[0] = ovf_a; ov_act[1] = ovf_b;
    end

    int     m_cyc;
    bit     m_busy [2];
    bit     m_done [2];
    int     m_left [2];
    longint m_pend [2];
    longint m_shown [2];
    longint m_prev [2];

    always @(posedge clk) begin
        if (rst) begin
            m_cyc <= 0;
            for (int i = 0; i < 2; i++) begin
                m_busy[i] <= 1'b0; m_done[i] <= 1'b0; m_left[i] <= 0;
                m_shown[i] <= 0; m_prev[i] <= 0;
            end
        end else begin
            m_cyc <= m_cyc + 1;
            for (int i = 0; i < 2; i++) begin
                m_prev[i] <= m_shown[i];
                m_done[i] <= 1'b0;
                if (!m_busy[i] && ld[i]) begin
                    m_busy[i] <= 1'b1;
                    m_left[i] <= pvw(i);
                    m_pend[i] <= nm[i];
                end else if (m_busy[i]) begin
                    if (m_left[i] == 1) begin
                        m_busy[i]  <= 1'b0;
                        m_done[i]  <= 1'b1;
                        m_shown[i] <= m_pend[i];
                    end else begin
                        m_left[i] <= m_left[i] - 1;
                    end
                end
            end
        end
    end

    // Every cycle: scan position, segments, handshake and overflow vs the model.
    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 2; i++) begin
                logic [7:0] ea;
                logic [6:0] el;
                int pos;
                ea = 8'((1 << pd(i)) - 1);
                el = 7'h7F;
                if (m_cyc != 0) begin
                    pos = pd(i) - 1 - (((m_cyc - 1) >> pr(i)) % pd(i));
                    ea[pos] = 1'b0;
                    el = exp_seg(i, m_prev[i], pos);
                end
                n_chk++;
                if (an_act[i] !== ea) begin
                    n_fail++;
                    $display("FAIL scan_anode[%0d] cyc %0d: got %b want %b", i, m_cyc, an_act[i], ea);
                end
                n_chk++;
                if (led_act[i] !== el) begin
                    n_fail++;
                    $display("FAIL scan_led[%0d] cyc %0d: got %b want %b", i, m_cyc, led_act[i], el);
                end
                n_chk++;
                if (bsy_act[i] !== m_busy[i]) begin
                    n_fail++;
                    $display("FAIL busy[%0d] cyc %0d: got %b want %b", i, m_cyc, bsy_act[i], m_busy[i]);
                end
                n_chk++;
                if (dn_act[i] !== m_done[i]) begin
                    n_fail++;
                    $display("FAIL done[%0d] cyc %0d: got %b want %b", i, m_cyc, dn_act[i], m_done[i]);
                end
                n_chk++;
                if (ov_act[i] !== (m_shown[i] > pw10(pd(i)) - 1)) begin
                    n_fail++;
                    $display("FAIL overflow[%0d] cyc %0d: got %b", i, m_cyc, ov_act[i]);
                end
            end
        end
    end

    task automatic test_reset();
        logic [6:0] want;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_chk++;
        if (an_a !== 4'hF) begin n_fail++; $display("FAIL reset_anode: got %b want 1111", an_a); end
        n_chk++;
        if (led_a !== 7'h7F) begin n_fail++; $display("FAIL reset_led: got %b want 1111111", led_a); end
        n_chk++;
        if ({busy_a, done_a, ovf_a} !== 3'b000) begin
            n_fail++; $display("FAIL reset_flags: got %b want 000", {busy_a, done_a, ovf_a});
        end
        rst = 1'b0;
        chk_en = 1'b1;
        @(negedge clk);
        want = LZB ? 7'h7F : SEG[0];
        n_chk++;
        if (an_a !== 4'b0111) begin n_fail++; $display("FAIL first_anode: got %b want 0111", an_a); end
        n_chk++;
        if (led_a !== want) begin n_fail++; $display("FAIL first_led: got %b want %b", led_a, want); end
        n_chk++;
        if (an_b !== 6'b011111) begin n_fail++; $display("FAIL first_anode_b: got %b want 011111", an_b); end
    endtask

    task automatic test_convert();
        logic [3:0] prev, want_an;
        bit got;
        num_a = 14'd1234; load_a = 1'b1;
        @(negedge clk);
        load_a = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            n_chk++;
            if (busy_a !== (k <= 14)) begin n_fail++; $display("FAIL conv_busy k=%0d: got %b", k, busy_a); end
            n_chk++;
            if (done_a !== (k == 15)) begin n_fail++; $display("FAIL conv_done k=%0d: got %b", k, done_a); end
            @(negedge clk);
        end
        got = 1'b0;
        prev = an_a;
        for (int w = 0; w < 40 && !got; w++) begin
            @(negedge clk);
            if (an_a == 4'b0111 && prev != 4'b0111) got = 1'b1;
            prev = an_a;
        end
        n_chk++;
        if (!got) begin n_fail++; $display("FAIL conv_scan_start: got timeout want 0111"); end
        for (int j = 0; j < 16; j++) begin
            want_an = 4'b1000 >> (j / 4);
            want_an = ~want_an;
            n_chk++;
            if (an_a !== want_an) begin n_fail++; $display("FAIL conv_anode j=%0d: got %b want %b", j, an_a, want_an); end
            n_chk++;
            if (led_a !== SEG[j / 4 + 1]) begin
                n_fail++; $display("FAIL conv_led j=%0d: got %b want %b", j, led_a, SEG[j / 4 + 1]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_boundary();
        longint vals [3] = '{9999, 10000, 0};
        for (int n = 0; n < 3; n++) begin
            bit got;
            num_a = 14'(vals[n]); load_a = 1'b1;
            @(negedge clk);
            load_a = 1'b0;
            got = 1'b0;
            for (int w = 0; w < 40 && !got; w++) begin
                if (done_a === 1'b1) got = 1'b1;
                else @(negedge clk);
            end
            n_chk++;
            if (!got) begin n_fail++; $display("FAIL bound_done %0d: got timeout want done", vals[n]); end
            n_chk++;
            if (ovf_a !== (vals[n] > 9999)) begin
                n_fail++; $display("FAIL bound_ovf %0d: got %b want %b", vals[n], ovf_a, vals[n] > 9999);
            end
            @(negedge clk);
            for (int j = 0; j < 16; j++) begin
                logic [6:0] want;
                int pos;
                pos = 0;
                for (int p = 0; p < 4; p++) if (an_a[p] == 1'b0) pos = p;
                if (n == 0) want = SEG[9];
                else if (n == 1) want = DASH;
                else want = (LZB && pos != 0) ? 7'h7F : SEG[0];
                n_chk++;
                if (led_a !== want) begin
                    n_fail++; $display("FAIL bound_led %0d pos %0d: got %b want %b", vals[n], pos, led_a, want);
                end
                @(negedge clk);
            end
        end
    endtask

    task automatic test_busy_reject();
        int dg [4] = '{4, 3, 2, 1};
        num_a = 14'd1234; load_a = 1'b1;
        @(negedge clk);
        load_a = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            logic [6:0] want;
            int pos;
            pos = 0;
            for (int p = 0; p < 4; p++) if (an_a[p] == 1'b0) pos = p;
            want = (LZB && pos != 0) ? 7'h7F : SEG[0];
            n_chk++;
            if (done_a !== (k == 15)) begin n_fail++; $display("FAIL rej_done k=%0d: got %b", k, done_a); end
            if (k <= 15) begin
                n_chk++;
                if (led_a !== want) begin n_fail++; $display("FAIL rej_hold k=%0d: got %b want %b", k, led_a, want); end
            end
            load_a = (k == 5);
            num_a  = (k == 5) ? 14'd5678 : 14'd1234;
            @(negedge clk);
        end
        for (int j = 0; j < 16; j++) begin
            int pos;
            pos = 0;
            for (int p = 0; p < 4; p++) if (an_a[p] == 1'b0) pos = p;
            n_chk++;
            if (led_a !== SEG[dg[pos]]) begin
                n_fail++; $display("FAIL rej_led pos %0d: got %b want %b", pos, led_a, SEG[dg[pos]]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid();
        logic [6:0] want;
        num_a = 14'd4321; load_a = 1'b1;
        @(negedge clk);
        load_a = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            n_chk++;
            if (busy_a !== 1'b1) begin n_fail++; $display("FAIL mid_busy k=%0d: got %b want 1", k, busy_a); end
            if (k == 7) rst = 1'b1;
            @(negedge clk);
        end
        n_chk++;
        if ({busy_a, done_a, an_a, led_a} !== {2'b00, 4'hF, 7'h7F}) begin
            n_fail++; $display("FAIL mid_reset: got %b want 0011111111111", {busy_a, done_a, an_a, led_a});
        end
        rst = 1'b0;
        @(negedge clk);
        want = LZB ? 7'h7F : SEG[0];
        n_chk++;
        if (an_a !== 4'b0111 || led_a !== want) begin
            n_fail++; $display("FAIL mid_restart: got %b/%b want 0111/%b", an_a, led_a, want);
        end
        for (int k = 0; k < 25; k++) begin
            n_chk++;
            if (done_a !== 1'b0 || busy_a !== 1'b0) begin
                n_fail++; $display("FAIL mid_nodone k=%0d: got %b%b want 00", k, busy_a, done_a);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_scaled();
        logic [5:0] prev, want_an;
        bit got;
        num_b = 20'd999999; load_b = 1'b1;
        @(negedge clk);
        load_b = 1'b0;
        for (int k = 1; k <= 22; k++) begin
            n_chk++;
            if (done_b !== (k == 21) || busy_b !== (k <= 20)) begin
                n_fail++; $display("FAIL scl_hs k=%0d: got busy %b done %b", k, busy_b, done_b);
            end
            @(negedge clk);
        end
        got = 1'b0;
        prev = an_b;
        for (int w = 0; w < 30 && !got; w++) begin
            @(negedge clk);
            if (an_b == 6'b011111 && prev != 6'b011111) got = 1'b1;
            prev = an_b;
        end
        n_chk++;
        if (!got) begin n_fail++; $display("FAIL scl_scan_start: got timeout want 011111"); end
        for (int j = 0; j < 12; j++) begin
            want_an = 6'b100000 >> (j / 2);
            want_an = ~want_an;
            n_chk++;
            if (an_b !== want_an || led_b !== SEG[9]) begin
                n_fail++; $display("FAIL scl_9s j=%0d: got %b/%b want %b/%b", j, an_b, led_b, want_an, SEG[9]);
            end
            @(negedge clk);
        end
        num_b = 20'd1000000; load_b = 1'b1;
        @(negedge clk);
        load_b = 1'b0;
        got = 1'b0;
        for (int w = 0; w < 40 && !got; w++) begin
            if (done_b === 1'b1) got = 1'b1;
            else @(negedge clk);
        end
        n_chk++;
        if (!got || ovf_b !== 1'b1) begin n_fail++; $display("FAIL scl_ovf: got done %b ovf %b want 1 1", got, ovf_b); end
        @(negedge clk);
        for (int j = 0; j < 12; j++) begin
            n_chk++;
            if (led_b !== DASH) begin n_fail++; $display("FAIL scl_dash j=%0d: got %b want %b", j, led_b, DASH); end
            @(negedge clk);
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 600; k++) begin
            if (done_a === 1'b1) begin
                n_chk++;
                if (ovf_a !== (m_shown[0] > 9999)) begin
                    n_fail++; $display("FAIL rnd_ovf val %0d: got %b", m_shown[0], ovf_a);
                end
            end
            load_a = ($urandom_range(0, 3) == 0);
            load_b = ($urandom_range(0, 3) == 0);
            num_a  = ($urandom_range(0, 1) == 0) ? 14'($urandom_range(9990, 10010))
                                                 : 14'($urandom_range(0, 16383));
            num_b  = 20'($urandom_range(0, 1048575));
            @(negedge clk);
        end
        load_a = 1'b0;
        load_b = 1'b0;
        repeat (40) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_convert();
        test_boundary();
        test_busy_reject();
        test_reset_mid();
        test_scaled();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
